// File: rtl/board_row_server.sv
// Row-fetch responder: reads one board row from synchronous RAM into a shadow buffer and
// commits it to Row in a single edge. Optional full-row detection: ROW_SERVER_FULL_DETECT_EN.
module board_row_server #(
   parameter int BOARD_W = 10,
   parameter int BOARD_H = 20,
   parameter int CELL_W  = 16
) (
   input  logic                             Clk,
   input  logic                             reset,
   input  logic                             LD_Row,
   input  logic [7:0]                       rowNum,
   output logic [7:0]                       mem_addr,
   output logic                             mem_rd,
   input  logic [CELL_W-1:0]                mem_data,
   output logic [BOARD_W-1:0][CELL_W-1:0]   Row,
   output logic                             rowReady,
   output logic                             busy,
   output logic                             rowFull
);
   // state  | meaning
   // IDLE   | waiting for a row request
   // READ   | issuing one RAM read per cycle, col 0..BOARD_W-1
   // DRAIN  | capturing the last cell still in flight
   // COMMIT | shadow -> Row, rowReady pulse on exit edge
   typedef enum logic [1:0] {IDLE, READ, DRAIN, COMMIT} state_t;

   localparam int            IW       = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;
   localparam logic [IW-1:0] LAST_COL = IW'(BOARD_W - 1);
   localparam logic [7:0]    W8       = 8'(BOARD_W);
   localparam logic [7:0]    H8       = 8'(BOARD_H);

   state_t                           state;
   logic [7:0]                       cur_row;
   logic [IW-1:0]                    col;
   logic                             pend_vld;
   logic [7:0]                       pend_row;
   logic                             cap_vld;
   logic [IW-1:0]                    cap_idx;
   logic [BOARD_W-1:0][CELL_W-1:0]   shadow;
   logic                             take_vld;
   logic [7:0]                       take_row;

   // Shift-add row*BOARD_W; only evaluated when a request is accepted.
   function automatic logic [7:0] row_base(input logic [7:0] r);
      logic [7:0] acc;
      acc = '0;
      for (int i = 0; i < 8; i++)
         if (W8[i]) acc = acc + (r << i);
      return acc;
   endfunction

`ifdef ROW_SERVER_FULL_DETECT_EN
   function automatic logic all_lit(input logic [BOARD_W-1:0][CELL_W-1:0] c);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < BOARD_W; i++)
         if (c[i][11:0] == 12'd0) ok = 1'b0;
      return ok;
   endfunction
`else
   assign rowFull = 1'b0;
`endif

   // A request on LD_Row in COMMIT wins over the stored pending one.
   always_comb begin
      take_vld = LD_Row | pend_vld;
      take_row = LD_Row ? rowNum : pend_row;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge Clk) begin
      if (reset) begin
         state    <= IDLE;
         cur_row  <= '0;
         col      <= '0;
         pend_vld <= 1'b0;
         pend_row <= '0;
         cap_vld  <= 1'b0;
         cap_idx  <= '0;
         shadow   <= '0;
         Row      <= '0;
         rowReady <= 1'b0;
         mem_rd   <= 1'b0;
         mem_addr <= '0;
`ifdef ROW_SERVER_FULL_DETECT_EN
         rowFull  <= 1'b0;
`endif
      end else begin
         cap_vld  <= mem_rd;
         cap_idx  <= col;
         if (cap_vld) shadow[cap_idx] <= mem_data;
         rowReady <= 1'b0;

         case (state)
            IDLE, COMMIT: begin
               if (state == COMMIT) begin
                  Row      <= shadow;
                  rowReady <= 1'b1;
`ifdef ROW_SERVER_FULL_DETECT_EN
                  rowFull  <= all_lit(shadow);
`endif
               end
               pend_vld <= 1'b0;
               if (!take_vld) begin
                  state <= IDLE;
               end else if (take_row < H8) begin
                  state    <= READ;
                  cur_row  <= take_row;
                  col      <= '0;
                  mem_rd   <= 1'b1;
                  mem_addr <= row_base(take_row);
               end else begin
                  // Out-of-range row: commit zeros without touching RAM.
                  shadow <= '0;
                  state  <= COMMIT;
               end
            end
            READ: begin
               if (LD_Row && rowNum != cur_row) begin
                  pend_vld <= 1'b1;
                  pend_row <= rowNum;
               end
               if (col == LAST_COL) begin
                  state    <= DRAIN;
                  mem_rd   <= 1'b0;
                  mem_addr <= '0;
               end else begin
                  col      <= col + 1'b1;
                  mem_addr <= mem_addr + 8'd1;
               end
            end
            DRAIN: begin
               if (LD_Row && rowNum != cur_row) begin
                  pend_vld <= 1'b1;
                  pend_row <= rowNum;
               end
               state <= COMMIT;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
